// File: rtl/visor_cuenta_7seg_pkg.sv
// Shared constants for the 2-digit multiplexed 7-segment count display.
//   - Scan state encodings (2-bit): S_UNI, S_APAG1, S_DEC, S_APAG2.
//   - Active-high segment patterns {g,f,e,d,c,b,a}: SEG_0..SEG_9, SEG_E, SEG_BLANK.
//   - Active-high anode patterns {tens, units}: AN_UNI, AN_DEC, AN_OFF.
//   - Internal digit codes handed to the decoder: 0..9, DIG_E, DIG_BLANK.
package visor_cuenta_7seg_pkg;

    localparam logic [1:0] S_UNI   = 2'd0;
    localparam logic [1:0] S_APAG1 = 2'd1;
    localparam logic [1:0] S_DEC   = 2'd2;
    localparam logic [1:0] S_APAG2 = 2'd3;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] AN_UNI = 2'b01;
    localparam logic [1:0] AN_DEC = 2'b10;
    localparam logic [1:0] AN_OFF = 2'b00;

    // Digit codes above 9 that the decoder understands.
    localparam logic [3:0] DIG_E     = 4'hE;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    // Largest legal count coming from the upstream mod-11 counter.
    localparam logic [3:0] CUENTA_MAX = 4'd10;

endpackage

// File: rtl/visor_cuenta_7seg_decodificador.sv
// decodificador_7seg: combinational digit code -> active-high 7-segment pattern.
//   digito     in  4  0..9 = decimal digit, DIG_E = 'E', anything else = blank
//   segmentos  out 7  pattern {g,f,e,d,c,b,a}
module decodificador_7seg
    import visor_cuenta_7seg_pkg::*;
(
    input  logic [3:0] digito,
    output logic [6:0] segmentos
);

    always_comb begin
        segmentos = SEG_BLANK;
        case (digito)
            4'd0:    segmentos = SEG_0;
            4'd1:    segmentos = SEG_1;
            4'd2:    segmentos = SEG_2;
            4'd3:    segmentos = SEG_3;
            4'd4:    segmentos = SEG_4;
            4'd5:    segmentos = SEG_5;
            4'd6:    segmentos = SEG_6;
            4'd7:    segmentos = SEG_7;
            4'd8:    segmentos = SEG_8;
            4'd9:    segmentos = SEG_9;
            DIG_E:   segmentos = SEG_E;
            default: segmentos = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/visor_cuenta_7seg.sv
// visor_cuenta_7seg: registers a 0..10 count and shows it on a 2-digit
// time-multiplexed 7-segment display with a 1-cycle blank between digits.
// Values 11..15 show 'E' on the units digit and raise o_error.
//   i_clk        in   1  clock, rising edge
//   i_rst        in   1  asynchronous active-high reset (outputs off)
//   i_cuenta     in   4  count from the upstream counter
//   o_segmentos  out  7  {g,f,e,d,c,b,a}, polarity set by ACTIVO_BAJO
//   o_anodos     out  2  [0] units, [1] tens, polarity set by ACTIVO_BAJO
//   o_error      out  1  registered count is out of range
module visor_cuenta_7seg
    import visor_cuenta_7seg_pkg::*;
#(
    parameter int CICLOS_REFRESCO = 4,
    parameter bit ACTIVO_BAJO     = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_cuenta,
    output logic [6:0] o_segmentos,
    output logic [1:0] o_anodos,
    output logic       o_error
);

    localparam int PW = (CICLOS_REFRESCO > 1) ? $clog2(CICLOS_REFRESCO) : 1;
    localparam logic [PW-1:0] PRESC_ULTIMO = PW'(CICLOS_REFRESCO - 1);

    // XOR masks turn the active-high encodings into the board polarity.
    localparam logic [6:0] SEG_MASK = {7{ACTIVO_BAJO}};
    localparam logic [1:0] AN_MASK  = {2{ACTIVO_BAJO}};

    logic [3:0]    cuenta_reg;
    logic [PW-1:0] presc_reg, presc_next;
    logic [1:0]    estado_reg, estado_next;
    logic          arranque_reg;
    logic [6:0]    seg_reg, seg_next;
    logic [1:0]    an_reg, an_next;
    logic          err_reg, err_next;
    logic          encendido;
    logic          tick;

    // [0] = units, [1] = tens
    logic [3:0]    digito [2];
    logic [6:0]    patron [2];

    // Split the registered count into digit codes.
    always_comb begin
        digito[0] = DIG_E;
        digito[1] = DIG_BLANK;
        if (cuenta_reg <= 4'd9) begin
            digito[0] = cuenta_reg;
        end else if (cuenta_reg == CUENTA_MAX) begin
            digito[0] = 4'd0;
            digito[1] = 4'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dec
            decodificador_7seg u_dec (
                .digito    (digito[gi]),
                .segmentos (patron[gi])
            );
        end
    endgenerate

    // The state left by reset already stands for S_UNI, but the first edge
    // after release must not consume a prescaler count, otherwise units would
    // be lit one cycle short. arranque_reg freezes scan timing for that edge.
    assign encendido = (estado_reg == S_UNI) || (estado_reg == S_DEC);
    assign tick      = encendido && !arranque_reg && (presc_reg == PRESC_ULTIMO);

    always_comb begin
        presc_next  = '0;
        estado_next = estado_reg;
        if (!arranque_reg) begin
            if (encendido && !tick) begin
                presc_next = presc_reg + 1'b1;
            end
            case (estado_reg)
                S_UNI:   estado_next = tick ? S_APAG1 : S_UNI;
                S_APAG1: estado_next = S_DEC;
                S_DEC:   estado_next = tick ? S_APAG2 : S_DEC;
                default: estado_next = S_UNI;
            endcase
        end
    end

    // Outputs come from the next state so anodes and segments switch together
    // with the state on the same edge.
    always_comb begin
        seg_next = SEG_BLANK;
        an_next  = AN_OFF;
        case (estado_next)
            S_UNI: begin
                seg_next = patron[0];
                an_next  = AN_UNI;
            end
            S_DEC: begin
                seg_next = patron[1];
                an_next  = AN_DEC;
            end
            default: begin
                seg_next = SEG_BLANK;
                an_next  = AN_OFF;
            end
        endcase
        err_next = (cuenta_reg > CUENTA_MAX);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cuenta_reg   <= '0;
            presc_reg    <= '0;
            estado_reg   <= S_UNI;
            arranque_reg <= 1'b1;
            seg_reg      <= SEG_BLANK ^ SEG_MASK;
            an_reg       <= AN_OFF ^ AN_MASK;
            err_reg      <= 1'b0;
        end else begin
            cuenta_reg   <= i_cuenta;
            presc_reg    <= presc_next;
            estado_reg   <= estado_next;
            arranque_reg <= 1'b0;
            seg_reg      <= seg_next ^ SEG_MASK;
            an_reg       <= an_next ^ AN_MASK;
            err_reg      <= err_next;
        end
    end

    assign o_segmentos = seg_reg;
    assign o_anodos    = an_reg;
    assign o_error     = err_reg;

endmodule
